// File: rtl/arb8way16_pkg.sv
// rtl/arb8way16_pkg.sv - shared state encodings and defaults for the 8-way arbiter
`ifndef ARB8WAY16_PKG_SV
`define ARB8WAY16_PKG_SV
package arb8way16_pkg;
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int DEFAULT_MAX_BURST = 16;
endpackage
`endif

// File: rtl/arb8way16_if.sv
// rtl/arb8way16_if.sv - requester/consumer handshake bundle for the 8-way arbiter
interface arb8way16_if #(
    parameter int WIDTH = 16
);
    logic [7:0]         req;
    logic [8*WIDTH-1:0] data_in;
    logic [7:0]         last;
    logic [7:0]         in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;
    logic               out_ready;
    logic [7:0]         grant;
    logic [2:0]         out_src;
    logic               busy;

    modport master (
        output req, data_in, last, out_ready,
        input  in_ready, out_valid, out_data, out_last, grant, out_src, busy
    );

    modport slave (
        input  req, data_in, last, out_ready,
        output in_ready, out_valid, out_data, out_last, grant, out_src, busy
    );
endinterface

// File: rtl/arb8way16_rr_pick8.sv
// rtl/arb8way16_rr_pick8.sv - combinational rotate-priority finder over 8 requests
module rr_pick8 (
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    output logic       valid,
    output logic [2:0] idx
);
    logic [15:0] dbl;
    logic [7:0]  rot;
    logic [2:0]  off;

    // Rotating right by ptr puts the highest-priority requester at bit 0.
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[7:0];

    always_comb begin
        off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) off = 3'(i);
        end
    end

    assign valid = |req;
    assign idx   = ptr + off;
endmodule

// File: rtl/arb8way16.sv
// rtl/arb8way16.sv - round-robin arbiter steering one of 8 burst streams to a shared sink
module arb8way16
    import arb8way16_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = DEFAULT_MAX_BURST,
    parameter int CW        = 5
) (
    input  logic          clk,
    input  logic          reset,
    arb8way16_if.slave    bus
);
    arb_state_e    state, state_n;
    logic [7:0]    grant_q, grant_n;
    logic [2:0]    src_q, src_n;
    logic [2:0]    ptr_q, ptr_n;
    logic [CW-1:0] cnt_q, cnt_n;

    logic          pick_valid;
    logic [2:0]    pick_idx;
    logic          busy;
    logic          out_valid;
    logic          out_last;
    logic [WIDTH-1:0] word;

    rr_pick8 u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign busy      = (state == ARB_BUSY);
    assign out_valid = busy & bus.req[src_q];
    assign out_last  = (bus.last[src_q] | (cnt_q == CW'(MAX_BURST - 1))) & out_valid;

    // Selection mux; forced to zero outside a grant so idle traffic never leaks.
    always_comb begin
        word = '0;
        for (int i = 0; i < 8; i++) begin
            if (busy && src_q == 3'(i)) word = bus.data_in[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ARB_IDLE;
            grant_q <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state   <= state_n;
            grant_q <= grant_n;
            src_q   <= src_n;
            ptr_q   <= ptr_n;
            cnt_q   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant_q;
        src_n   = src_q;
        ptr_n   = ptr_q;
        cnt_n   = cnt_q;
        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_n = ARB_BUSY;
                    grant_n = 8'b1 << pick_idx;
                    src_n   = pick_idx;
                    cnt_n   = '0;
                end
            end
            ARB_BUSY: begin
                if (out_valid && bus.out_ready) begin
                    if (out_last) begin
                        // The winner drops to lowest priority for the next round.
                        state_n = ARB_IDLE;
                        grant_n = '0;
                        src_n   = '0;
                        ptr_n   = src_q + 3'd1;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + CW'(1);
                    end
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    assign bus.grant     = grant_q;
    assign bus.out_src   = src_q;
    assign bus.busy      = busy;
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.out_data  = word;
    assign bus.in_ready  = grant_q & {8{bus.out_ready}};
endmodule
